// File: rtl/rom_dl_pkg.sv
// Shared types and helpers for the ioctl ROM download router.
// Region decode is a priority scan over ascending region base addresses.
package rom_dl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DRAIN,
      ST_HOLD,
      ST_DONE
   } state_t;

   localparam int CSUM_W      = 16;
   localparam int MAX_REGIONS = 8;

   // Highest region whose base is at or below addr; bases are 32-bit zero-extended slices.
   function automatic logic [2:0] region_of(
      input logic [31:0]               addr,
      input logic [MAX_REGIONS*32-1:0] bases,
      input int                        num
   );
      logic [2:0] r;
      r = '0;
      for (int i = 0; i < MAX_REGIONS; i++) begin
         if (i < num && addr >= bases[i*32 +: 32]) r = 3'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/rom_dl_skid.sv
// One-entry pending register with ready/wait handshake.
// A new entry is taken when empty or when the current one drains this cycle.
module rom_dl_skid #(
   parameter int W = 8
) (
   input  logic         clk_sys,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   input  logic         ready,
   output logic         pending,
   output logic [W-1:0] out_data,
   output logic         fire,
   output logic         wait_req
);

   logic capture;

   assign fire     = pending & ready;
   assign wait_req = pending & ~ready;
   // An arrival while stalled is dropped so the held entry stays stable.
   assign capture  = in_valid & (~pending | ready);

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         pending  <= 1'b0;
         out_data <= '0;
      end else if (capture) begin
         pending  <= 1'b1;
         out_data <= in_data;
      end else if (fire) begin
         pending  <= 1'b0;
      end
   end

endmodule

// File: rtl/rom_download_router.sv
// Routes the hps_io ioctl byte stream into per-region ROM write strobes,
// tracks a load checksum and holds the game core in reset until loaded.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no load seen since reset
// ST_LOAD  | download active, bytes captured and forwarded
// ST_DRAIN | download ended, waiting for the last pending byte
// ST_HOLD  | core kept in reset for HOLD_CYCLES after the final byte
// ST_DONE  | ROM loaded, core released
module rom_download_router
   import rom_dl_pkg::*;
#(
   parameter int                          NUM_REGIONS = 4,
   parameter int                          ADDR_W      = 25,
   parameter int                          REGION_AW   = 14,
   parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE =
      {25'h3000, 25'h2000, 25'h1000, 25'h0},
   parameter logic [ADDR_W-1:0]           TOTAL_SIZE  = 25'h4000,
   parameter logic [7:0]                  LOAD_INDEX  = 8'd0,
   parameter int                          HOLD_CYCLES = 16
) (
   input  logic                   clk_sys,
   input  logic                   RESET_n,
   input  logic                   ioctl_download,
   input  logic [7:0]             ioctl_index,
   input  logic                   ioctl_wr,
   input  logic [ADDR_W-1:0]      ioctl_addr,
   input  logic [7:0]             ioctl_dout,
   output logic                   ioctl_wait,
   input  logic                   dn_ready,
   output logic [NUM_REGIONS-1:0] rom_we,
   output logic [REGION_AW-1:0]   rom_addr,
   output logic [7:0]             rom_data,
   output logic                   core_reset_n,
   output logic                   load_done,
   output logic [CSUM_W-1:0]      checksum,
   output logic                   overflow,
   output logic                   short_load
);

   localparam int RIDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
   localparam int PAY_W  = RIDX_W + REGION_AW + 8;
   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   state_t                   state, state_nxt;
   logic                     idx_match, start_load, wr_ok, in_range;
   logic [MAX_REGIONS*32-1:0] bases32;
   logic [2:0]               region;
   logic [RIDX_W-1:0]        ridx, pend_ridx;
   logic [ADDR_W-1:0]        base_sel;
   logic [REGION_AW-1:0]     rel;
   logic                     pend, fire;
   logic [PAY_W-1:0]         pay;
   logic [ADDR_W-1:0]        count, count_inc, count_after;
   logic [HOLD_W-1:0]        hold_tmr;

   assign idx_match  = (ioctl_index == LOAD_INDEX);
   assign start_load = ioctl_download & idx_match;
   assign wr_ok      = (state == ST_LOAD) & ioctl_wr & idx_match;
   assign in_range   = (ioctl_addr < TOTAL_SIZE);

   always_comb begin
      bases32 = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         bases32[i*32 +: 32] = 32'(REGION_BASE[i*ADDR_W +: ADDR_W]);
      end
      region   = region_of(32'(ioctl_addr), bases32, NUM_REGIONS);
      ridx     = RIDX_W'(region);
      base_sel = REGION_BASE[ridx*ADDR_W +: ADDR_W];
      rel      = REGION_AW'(ioctl_addr - base_sel);
   end

   rom_dl_skid #(.W(PAY_W)) u_skid (
      .clk_sys  (clk_sys),
      .rst_n    (RESET_n),
      .in_valid (wr_ok & in_range),
      .in_data  ({ridx, rel, ioctl_dout}),
      .ready    (dn_ready),
      .pending  (pend),
      .out_data (pay),
      .fire     (fire),
      .wait_req (ioctl_wait)
   );

   assign pend_ridx = pay[PAY_W-1 -: RIDX_W];
   assign rom_addr  = pay[8 +: REGION_AW];
   assign rom_data  = pay[7:0];

   always_comb begin
      rom_we = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         rom_we[i] = fire & (pend_ridx == RIDX_W'(i));
      end
   end

   assign count_inc   = (count == '1) ? count : count + 1'b1;
   assign count_after = fire ? count_inc : count;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start_load)      state_nxt = ST_LOAD;
         ST_LOAD:  if (!ioctl_download) state_nxt = ST_DRAIN;
         // Leave as soon as nothing will be pending next cycle, so the hold
         // window starts right after the final strobe.
         ST_DRAIN: if (!pend || fire)   state_nxt = ST_HOLD;
         ST_HOLD:  if (hold_tmr == '0)  state_nxt = ST_DONE;
         ST_DONE:  if (start_load)      state_nxt = ST_LOAD;
         default:                       state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge RESET_n) begin
      if (!RESET_n) begin
         state      <= ST_IDLE;
         checksum   <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         short_load <= 1'b0;
         hold_tmr   <= '0;
      end else begin
         state <= state_nxt;
         if (state != ST_LOAD && state_nxt == ST_LOAD) begin
            checksum   <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            short_load <= 1'b0;
         end else begin
            if (fire) begin
               checksum <= checksum + CSUM_W'(rom_data);
               count    <= count_inc;
            end
            if (wr_ok && !in_range) overflow <= 1'b1;
            if (state == ST_DRAIN && state_nxt == ST_HOLD) begin
               short_load <= (count_after < TOTAL_SIZE);
            end
         end
         if (state == ST_DRAIN && state_nxt == ST_HOLD) begin
            hold_tmr <= HOLD_W'(HOLD_CYCLES - 1);
         end else if (state == ST_HOLD && hold_tmr != '0) begin
            hold_tmr <= hold_tmr - 1'b1;
         end
      end
   end

   assign load_done    = (state == ST_DONE);
   assign core_reset_n = (state == ST_DONE);

endmodule

// File: tb/tb_rom_download_router.sv
// Randomized directed bench for rom_download_router: a queue of expected
// strobes built from the address map is checked by a negedge monitor.
module tb_rom_download_router;

   localparam int HOLD  = 16;
   localparam int TOTAL = 'h4000;

   logic        clk_sys = 1'b0;
   logic        RESET_n = 1'b0;
   logic        ioctl_download = 1'b0;
   logic [7:0]  ioctl_index = 8'd0;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = '0;
   logic        dn_ready = 1'b1;
   logic        ioctl_wait;
   logic [3:0]  rom_we;
   logic [13:0] rom_addr;
   logic [7:0]  rom_data;
   logic        core_reset_n, load_done, overflow, short_load;
   logic [15:0] checksum;

   rom_download_router dut (
      .clk_sys        (clk_sys),
      .RESET_n        (RESET_n),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wait     (ioctl_wait),
      .dn_ready       (dn_ready),
      .rom_we         (rom_we),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .core_reset_n   (core_reset_n),
      .load_done      (load_done),
      .checksum       (checksum),
      .overflow       (overflow),
      .short_load     (short_load)
   );

   typedef struct {
      int region;
      int rel;
      int data;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   last_we_cyc = 0;
   int   we_cnt[4] = '{default: 0};
   int   base_cnt[4];
   int   sum = 0;
   int   bases[4] = '{0, 'h1000, 'h2000, 'h3000};

   always #5 clk_sys = ~clk_sys;
   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // Reference: region = highest base not above addr; relative address wraps at 14 bits.
   function automatic void model_write(input int a, input int d);
      exp_t e;
      int   r;
      r = 0;
      if (a >= TOTAL) return;
      for (int i = 0; i < 4; i++) if (a >= bases[i]) r = i;
      e.region = r;
      e.rel    = (a - bases[r]) & 'h3FFF;
      e.data   = d;
      exp_q.push_back(e);
      sum = (sum + d) % 65536;
   endfunction

   always @(negedge clk_sys) begin
      if (RESET_n && rom_we != 4'b0) begin
         exp_t e;
         last_we_cyc = cyc;
         if (exp_q.size() == 0) begin
            chk("unexpected_we", {28'b0, rom_we}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("we_bits", {28'b0, rom_we}, 32'(1 << e.region));
            chk("we_addr", {18'b0, rom_addr}, 32'(e.rel));
            chk("we_data", {24'b0, rom_data}, 32'(e.data));
         end
         for (int i = 0; i < 4; i++) if (rom_we[i]) we_cnt[i]++;
      end
   end

   task automatic chk_all_zero(input string pfx);
      chk({pfx, "_rom_we"},   {28'b0, rom_we}, 0);
      chk({pfx, "_rom_addr"}, {18'b0, rom_addr}, 0);
      chk({pfx, "_rom_data"}, {24'b0, rom_data}, 0);
      chk({pfx, "_wait"},     {31'b0, ioctl_wait}, 0);
      chk({pfx, "_core_rst"}, {31'b0, core_reset_n}, 0);
      chk({pfx, "_done"},     {31'b0, load_done}, 0);
      chk({pfx, "_csum"},     {16'b0, checksum}, 0);
      chk({pfx, "_ovf"},      {31'b0, overflow}, 0);
      chk({pfx, "_short"},    {31'b0, short_load}, 0);
   endtask

   task automatic wait_done(input bit check_delay);
      int n;
      n = 0;
      do begin
         @(negedge clk_sys);
         n++;
      end while (load_done !== 1'b1 && n < 300);
      chk("done_timeout", {31'b0, load_done}, 1);
      chk("done_core_rst", {31'b0, core_reset_n}, 1);
      if (check_delay) chk("hold_delay", 32'(cyc - last_we_cyc), HOLD + 1);
   endtask

   task automatic do_load(input int n, input bit gaps);
      int d, expc;
      exp_q.delete();
      sum = 0;
      for (int i = 0; i < 4; i++) base_cnt[i] = we_cnt[i];
      ioctl_index = 8'd0;
      ioctl_download = 1'b1;
      ioctl_wr = 1'b0;
      dn_ready = 1'b1;
      tick();
      chk("start_done", {31'b0, load_done}, 0);
      chk("start_core_rst", {31'b0, core_reset_n}, 0);
      chk("start_csum", {16'b0, checksum}, 0);
      chk("start_ovf", {31'b0, overflow}, 0);
      chk("start_short", {31'b0, short_load}, 0);
      for (int a = 0; a < n; a++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            ioctl_wr = 1'b0;
            tick();
         end
         d = int'($urandom_range(0, 255));
         ioctl_wr   = 1'b1;
         ioctl_addr = 25'(a);
         ioctl_dout = 8'(d);
         if (a == n - 1) ioctl_download = 1'b0;
         model_write(a, d);
         tick();
      end
      ioctl_wr = 1'b0;
      wait_done(1'b1);
      chk("drained", 32'(exp_q.size()), 0);
      chk("load_csum", {16'b0, checksum}, 32'(sum));
      chk("load_short", {31'b0, short_load}, {31'b0, n < TOTAL});
      chk("load_ovf", {31'b0, overflow}, 0);
      for (int i = 0; i < 4; i++) begin
         expc = n - 4096 * i;
         if (expc < 0) expc = 0;
         if (expc > 4096) expc = 4096;
         chk("we_count", 32'(we_cnt[i] - base_cnt[i]), 32'(expc));
      end
   endtask

   initial begin
      int   d;
      int   csum_keep;

      #7;
      chk_all_zero("reset");
      @(posedge clk_sys);
      #1 RESET_n = 1'b1;
      tick();
      chk("idle_done", {31'b0, load_done}, 0);

      // Foreign index while idle: must stay idle with no strobes.
      ioctl_index = 8'd1;
      ioctl_download = 1'b1;
      for (int k = 0; k < 3; k++) begin
         ioctl_wr = 1'b1;
         ioctl_addr = 25'($urandom_range(0, TOTAL - 1));
         ioctl_dout = 8'($urandom_range(0, 255));
         tick();
      end
      ioctl_wr = 1'b0;
      ioctl_download = 1'b0;
      tick();
      tick();
      chk("idx1_idle_done", {31'b0, load_done}, 0);
      chk("idx1_idle_core", {31'b0, core_reset_n}, 0);

      do_load(TOTAL, 1'b0);

      // Stall, protocol violation and out-of-range bytes in one load.
      exp_q.delete();
      sum = 0;
      ioctl_index = 8'd0;
      ioctl_download = 1'b1;
      tick();
      chk("l2_done_low", {31'b0, load_done}, 0);
      chk("l2_core_low", {31'b0, core_reset_n}, 0);
      chk("l2_csum_clr", {16'b0, checksum}, 0);
      d = int'($urandom_range(0, 255));
      ioctl_wr = 1'b1;
      ioctl_addr = 25'h1005;
      ioctl_dout = 8'(d);
      dn_ready = 1'b0;
      model_write('h1005, d);
      for (int k = 0; k < 5; k++) begin
         tick();
         ioctl_wr = (k == 2);
         ioctl_addr = 25'h1006;
         ioctl_dout = ~8'(d);
         @(negedge clk_sys);
         chk("stall_wait", {31'b0, ioctl_wait}, 1);
         chk("stall_addr", {18'b0, rom_addr}, 'h005);
         chk("stall_data", {24'b0, rom_data}, 32'(d));
         chk("stall_we", {28'b0, rom_we}, 0);
      end
      tick();
      ioctl_wr = 1'b0;
      dn_ready = 1'b1;
      @(negedge clk_sys);
      chk("release_wait", {31'b0, ioctl_wait}, 0);
      tick();
      chk("stall_csum", {16'b0, checksum}, 32'(sum));
      ioctl_wr = 1'b1;
      ioctl_addr = 25'h4000;
      ioctl_dout = 8'($urandom_range(0, 255));
      tick();
      ioctl_addr = 25'h7FFF;
      tick();
      ioctl_wr = 1'b0;
      tick();
      chk("ovf_set", {31'b0, overflow}, 1);
      chk("ovf_csum", {16'b0, checksum}, 32'(sum));
      ioctl_download = 1'b0;
      wait_done(1'b0);
      chk("l2_drained", 32'(exp_q.size()), 0);
      chk("l2_short", {31'b0, short_load}, 1);
      chk("l2_ovf_sticky", {31'b0, overflow}, 1);
      chk("l2_csum", {16'b0, checksum}, 32'(sum));

      do_load('h3000, 1'b1);
      csum_keep = sum;

      // Foreign index while done: nothing changes.
      ioctl_index = 8'd1;
      ioctl_download = 1'b1;
      for (int k = 0; k < 4; k++) begin
         ioctl_wr = 1'b1;
         ioctl_addr = 25'($urandom_range(0, TOTAL - 1));
         ioctl_dout = 8'($urandom_range(0, 255));
         tick();
      end
      ioctl_wr = 1'b0;
      ioctl_download = 1'b0;
      tick();
      tick();
      chk("idx1_done_done", {31'b0, load_done}, 1);
      chk("idx1_done_core", {31'b0, core_reset_n}, 1);
      chk("idx1_done_csum", {16'b0, checksum}, 32'(csum_keep));

      // Asynchronous reset with a byte stuck pending.
      exp_q.delete();
      sum = 0;
      ioctl_index = 8'd0;
      ioctl_download = 1'b1;
      tick();
      for (int a = 0; a < 10; a++) begin
         d = int'($urandom_range(0, 255));
         ioctl_wr = 1'b1;
         ioctl_addr = 25'(a);
         ioctl_dout = 8'(d);
         model_write(a, d);
         tick();
      end
      ioctl_addr = 25'h2000;
      dn_ready = 1'b0;
      model_write('h2000, int'(ioctl_dout));
      tick();
      ioctl_wr = 1'b0;
      chk("prerst_wait", {31'b0, ioctl_wait}, 1);
      #2 RESET_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      exp_q.delete();
      dn_ready = 1'b1;
      tick();
      tick();
      RESET_n = 1'b1;
      do_load(TOTAL, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
